// File: rtl/ntt_cmd_sequencer_pkg.sv
// Shared definitions for the ComputeCore command sequencer.
//   - seq_state_t : sequencer FSM states
//   - CMD_W       : ComputeCore command width
//   - INS_LSB/MSB : position of the INS (opcode) field inside a command
//   - OP_*        : ComputeCore opcode values
package ntt_cmd_sequencer_pkg;

  localparam int CMD_W   = 35;
  localparam int INS_LSB = 0;
  localparam int INS_MSB = 4;

  localparam logic [4:0] OP_NOP     = 5'd0;
  localparam logic [4:0] OP_TRNG    = 5'd18;
  localparam logic [4:0] OP_AES_ENC = 5'd19;
  localparam logic [4:0] OP_AES_DEC = 5'd20;
  localparam logic [4:0] OP_PADD    = 5'd22;
  localparam logic [4:0] OP_PSUB    = 5'd23;
  localparam logic [4:0] OP_PMUL    = 5'd24;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    LOAD    = 4'd2,
    ISSUE   = 4'd3,
    WAIT    = 4'd4,
    RELEASE = 4'd5,
    SETTLE  = 4'd6,
    ADVANCE = 4'd7,
    DONE    = 4'd8
  } seq_state_t;

endpackage

// File: rtl/ntt_cmd_prog_ram.sv
// Program store for the command sequencer: DEPTH x WIDTH simple dual-port RAM.
//   clk   : clock
//   we    : write strobe
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, registered (one cycle after raddr)
// A read and a write to the same address in one cycle return the old word.
// Contents are deliberately not reset.
module ntt_cmd_prog_ram
  import ntt_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int WIDTH  = 36
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ntt_cmd_sequencer.sv
// Upstream command issuer for ComputeCore. The host preloads a program of
// (CMD_W+1)-bit words (bit CMD_W = AUX flag); on start each word is issued on
// the command port, the sequencer waits for completion, then writes an idle
// command (INS=0) to hold the unit in reset before moving on.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   prog_we/addr/data     : program RAM write port (ignored while busy)
//   prog_len              : words to run (0..DEPTH), sampled on start
//   start                 : start pulse (ignored while busy)
//   command_out           : command to ComputeCore command_in (registered)
//   command_we0/we1       : main / auxiliary command register write strobes
//   done_ins_computation  : ComputeCore completion level (sampled directly)
//   busy, done            : run in progress / one-cycle end-of-program pulse
//   timeout_err           : sticky watchdog error, cleared by an accepted start
//   pc                    : index of the word in flight
//   state_dbg             : current FSM state (seq_state_t encoding)
//
// Command port handshake: a command is transferred on every cycle where
// command_we0 or command_we1 is high (one cycle each, never both); for a
// non-AUX, non-NOP command the unit signals completion by holding
// done_ins_computation high, which is consumed only in WAIT, and must drop
// once the idle command (command_out=0 with command_we0) has been written.
module ntt_cmd_sequencer #(
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int CMD_W     = 35,
  parameter int TIMEOUT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [CMD_W:0]    prog_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  output logic [CMD_W-1:0]  command_out,
  output logic              command_we0,
  output logic              command_we1,
  input  logic              done_ins_computation,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        state_dbg
);
  import ntt_cmd_sequencer_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  seq_state_t          state, state_next;
  logic [ADDR_W-1:0]   pc_next;
  logic [ADDR_W:0]     len_q, len_next;
  logic [CMD_W:0]      cmd_q, cmd_next;
  logic [TIMEOUT_W-1:0] wd_q, wd_next, wd_inc;
  logic                abort_q, abort_next;
  logic                terr_next;
  logic [CMD_W-1:0]    cmd_out_next;
  logic                we0_next, we1_next, busy_next, done_next;
  logic                ram_we;
  logic [CMD_W:0]      ram_rdata;

  // Writes are only accepted when no run is in progress.
  assign ram_we    = prog_we && ((state == IDLE) || (state == DONE));
  assign wd_inc    = wd_q + 1'b1;
  assign state_dbg = state;

  ntt_cmd_prog_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .WIDTH (CMD_W + 1)
  ) u_prog_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      len_q       <= '0;
      cmd_q       <= '0;
      wd_q        <= '0;
      abort_q     <= 1'b0;
      timeout_err <= 1'b0;
      command_out <= '0;
      command_we0 <= 1'b0;
      command_we1 <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      len_q       <= len_next;
      cmd_q       <= cmd_next;
      wd_q        <= wd_next;
      abort_q     <= abort_next;
      timeout_err <= terr_next;
      command_out <= cmd_out_next;
      command_we0 <= we0_next;
      command_we1 <= we1_next;
      busy        <= busy_next;
      done        <= done_next;
    end
  end

  // Outputs are registered: each *_next value is what the port shows while
  // the FSM sits in state_next.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    len_next     = len_q;
    cmd_next     = cmd_q;
    wd_next      = wd_q;
    abort_next   = abort_q;
    terr_next    = timeout_err;
    cmd_out_next = '0;
    we0_next     = 1'b0;
    we1_next     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          pc_next    = '0;
          len_next   = prog_len;
          terr_next  = 1'b0;
          abort_next = 1'b0;
          state_next = (prog_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_next = LOAD;
      LOAD: begin
        // RAM data is valid now; drive the ISSUE-cycle outputs straight from it.
        cmd_next     = ram_rdata;
        wd_next      = '0;
        cmd_out_next = ram_rdata[CMD_W-1:0];
        if (ram_rdata[CMD_W]) begin
          we1_next = 1'b1;
        end else begin
          we0_next = 1'b1;
        end
        state_next = ISSUE;
      end
      ISSUE: begin
        if (cmd_q[CMD_W] || (cmd_q[INS_MSB:INS_LSB] == OP_NOP)) begin
          state_next = ADVANCE;
        end else begin
          cmd_out_next = cmd_q[CMD_W-1:0];
          state_next   = WAIT;
        end
      end
      WAIT: begin
        if (done_ins_computation) begin
          we0_next   = 1'b1;
          state_next = RELEASE;
        end else if (&wd_inc) begin
          // Watchdog expiry: release the unit and skip the rest of the program.
          terr_next  = 1'b1;
          abort_next = 1'b1;
          we0_next   = 1'b1;
          state_next = RELEASE;
        end else begin
          wd_next      = wd_inc;
          cmd_out_next = cmd_q[CMD_W-1:0];
        end
      end
      // Gives done_ins_computation a cycle to fall before the next issue.
      RELEASE: state_next = SETTLE;
      SETTLE:  state_next = ADVANCE;
      ADVANCE: begin
        if (abort_q || ({1'b0, pc} == (len_q - 1'b1)) || (pc == LAST_ADDR)) begin
          state_next = DONE;
        end else begin
          pc_next    = pc + 1'b1;
          state_next = FETCH;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE) && (state_next != DONE);
    done_next = (state_next == DONE);
  end

endmodule

// File: doc/ntt_cmd_sequencer.md
Name: ntt_cmd_sequencer

Overview:
Upstream command issuer for the ComputeCore cryptoprocessor. The host preloads a short program of 36-bit command words; on `start` the block issues each one in turn over the ComputeCore command port. For each command it waits for `done_ins_computation`, then writes an idle command (INS=0) so the selected unit is held in reset again, and moves to the next word. This removes per-instruction host handshaking for NTT/poly-mult/add/sub sequences.

Parameters:
DEPTH, 32, number of program words
ADDR_W, 5, log2(DEPTH)
CMD_W, 35, ComputeCore command width (INS[4:0], OP1[14:5], OP2[24:15], OP3[34:25])
TIMEOUT_W, 20, width of the WAIT watchdog counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
prog_we  in  1  program RAM write strobe; ignored while busy
prog_addr  in  ADDR_W  program RAM write address
prog_data  in  CMD_W+1  bit CMD_W = AUX flag; bits CMD_W-1:0 = command
prog_len  in  ADDR_W+1  number of words to run, 0..DEPTH; sampled on start
start  in  1  start pulse; ignored while busy
command_out  out  CMD_W  command to ComputeCore `command_in`
command_we0  out  1  write strobe for main command register
command_we1  out  1  write strobe for auxiliary command register
done_ins_computation  in  1  ComputeCore completion level
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at end of program
timeout_err  out  1  sticky watchdog error; cleared by the next accepted start
pc  out  ADDR_W  index of the word currently in flight

Behaviour:
- Reset values: all outputs 0, state IDLE, pc 0, watchdog counter 0. Program RAM contents are not reset.
- Reset mid-run: the sequencer returns to IDLE on the next edge. No release command is issued, because ComputeCore shares the same rst.
- Program RAM: synchronous read, 1-cycle latency. A write and a read to the same address in the same cycle returns the old data.
- IDLE → FETCH: on start with prog_len≠0. Set pc=0, latch prog_len, clear timeout_err.
- IDLE → DONE: on start with prog_len=0.
- FETCH: present address pc to the RAM; next state LOAD.
- LOAD: RAM data valid; register it into cmd_q; next state ISSUE.
- ISSUE: command_out=cmd_q[CMD_W-1:0], asserted for exactly 1 cycle.
  - AUX=1: assert command_we1; next state ADVANCE (no wait).
  - AUX=0 and INS=0: assert command_we0; next state ADVANCE (NOP).
  - Otherwise: assert command_we0; next state WAIT.
- WAIT: hold command_out=cmd_q; increment the watchdog each cycle.
  - done_ins_computation=1 → RELEASE, even if it is already high in the first WAIT cycle.
  - Watchdog reaches all-ones before done → set timeout_err, abort flag, → RELEASE.
- RELEASE: command_out=0 and command_we0=1 for 1 cycle (INS=0, all units reset); next state SETTLE.
- SETTLE: 1 idle cycle so that done_ins_computation falls before the next issue; next state ADVANCE.
- ADVANCE:
  - If abort is set, or pc = len-1 → DONE.
  - Otherwise pc+1, → FETCH.
  - pc never wraps past DEPTH-1.
- DONE: done=1 for 1 cycle, busy=0 from this cycle; → IDLE.
- busy=1 in every state except IDLE and DONE.
- command_we0 and command_we1 are never asserted in the same cycle. Both are 0 outside ISSUE/RELEASE.
- Minimum per-command overhead on the command port: FETCH, LOAD, ISSUE, RELEASE, SETTLE, ADVANCE = 6 cycles, plus the unit's own latency.
- All command outputs are registered (glitch-free); done_ins_computation is sampled directly.

Decomposition:
- Shared package holds:
  - state enum IDLE, FETCH, LOAD, ISSUE, WAIT, RELEASE, SETTLE, ADVANCE, DONE
  - CMD_W, INS field LSB/MSB
  - opcode constants: NOP=0, TRNG=18, AES_ENC=19, AES_DEC=20, PADD=22, PSUB=23, PMUL=24
- One sub-module: ntt_cmd_prog_ram, a DEPTH×(CMD_W+1) simple-dual-port RAM with synchronous read.

Test Plan:
1. Load word0 = PMUL (INS=24, OP1=0, OP3=16); prog_len=1; start; model asserts done_ins 20 cycles after the we0 edge.
   → Exactly one we0 with INS=24; then one we0 with command 0; done pulses once; busy low afterwards.
2. Load 3 words [PADD, AUX word 0x7_0000_0001 with bit35=1, PSUB]; prog_len=3.
   → Order is we0(22), we0(0), we1(aux), we0(23), we0(0); done once; pc sequence 0, 1, 2.
3. prog_len=0 start → done on the 2nd cycle; no we0/we1 ever asserted.
4. TIMEOUT_W=4, model never asserts done_ins.
   → After 15 WAIT cycles: timeout_err=1, release command issued, remaining words skipped, done pulses.
   → The next start clears timeout_err.
5. Assert rst during WAIT.
   → Next cycle all outputs 0, state IDLE.
   → A start then runs the program from pc=0 correctly.
6. prog_we and start during busy.
   → RAM unchanged (read back after done); run not restarted; done count = 1.
